// File: rtl/multicycle_cpu_control_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states and datapath select codes.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b000101;
    localparam logic [5:0] OP_BEQ   = 6'b000110;
    localparam logic [5:0] OP_J     = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b001001;

    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [1:0] ALUB_RT    = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_AND    = 2'b11;

    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;
    localparam logic [1:0] PC_RS      = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_cpu_control_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_cpu_control_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int RETIRE_W = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                mem_ready;
    logic                stall;
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                branch;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                jal;
    logic                instr_done;
    logic                fault;
    logic [1:0]          fault_code;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode, funct, mem_ready, stall,
        output mem_read, mem_write, iord, ir_write, pc_write, branch, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, jal,
               instr_done, fault, fault_code, retired
    );

    modport slave (
        output opcode, funct, mem_ready, stall,
        input  mem_read, mem_write, iord, ir_write, pc_write, branch, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, jal,
               instr_done, fault, fault_code, retired
    );
endinterface

// File: rtl/multicycle_cpu_control_timer.sv
// Memory wait-state watchdog: down-counter reloaded on clr, expire flags the last allowed wait cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= LOAD;
        end else if (clr) begin
            count <= LOAD;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // Terminal count reached while still waiting: this is the MEM_TIMEOUT-th consecutive wait.
    assign expire = en && (count == '0);

endmodule

// File: rtl/multicycle_cpu_control.sv
// Multicycle instruction sequencer: drives datapath muxes/enables, watches memory wait states,
// reports sticky faults and counts retired instructions.
//
//  state  | meaning
//  IDLE   | post-reset, start fetching next cycle
//  FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
//  DECODE | latch opcode, precompute branch target, dispatch
//  MEMADR | compute load/store address
//  MEMRD  | load data read, waits on mem_ready
//  MEMWB  | write MDR to rt, retire
//  MEMWR  | store data write, retire on mem_ready
//  EXEC   | R-type ALU operation
//  ALUWB  | write ALUOut to rd, retire
//  IMMEX  | ADDI/ANDI ALU operation
//  IMMWB  | write ALUOut to rt, retire
//  BRANCH | BEQ compare and conditional PC load, retire
//  JUMP   | J, retire
//  JAL    | J plus link to r31, retire
//  JR     | PC from rs, retire
//  FAULT  | parked until reset
module multicycle_cpu_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int FUNCT_W     = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_cpu_control_if.master ctl
);
    state_t state, stateNext;

    logic [OPCODE_W-1:0] opLatched;
    logic [1:0]          faultCode, faultCodeNext;
    logic [RETIRE_W-1:0] retiredCnt;
    logic                retire;
    logic                readyEff, waitState;
    logic                timerClr, timerEn, timerExpire;

    logic       memRead, memWriteRaw, iord, irWriteRaw, pcWriteRaw, branchRaw, regWriteRaw;
    logic       regDst, memToReg, aluSrcA, jal;
    logic [1:0] aluSrcB, aluOp, pcSrc;

    // A stalled cycle must not see mem_ready, otherwise FETCH/MEMRD/MEMWR could advance.
    assign readyEff  = ctl.mem_ready & ~ctl.stall;
    assign waitState = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timerEn   = waitState & ~ctl.mem_ready & ~ctl.stall;
    assign timerClr  = (stateNext != state);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timerClr),
        .en     (timerEn),
        .expire (timerExpire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            faultCode  <= FC_NONE;
            retiredCnt <= '0;
            opLatched  <= '0;
        end else begin
            state     <= stateNext;
            faultCode <= faultCodeNext;
            if (retire) begin
                retiredCnt <= retiredCnt + RETIRE_W'(1);
            end
            if ((state == S_DECODE) && !ctl.stall) begin
                opLatched <= ctl.opcode;
            end
        end
    end

    always_comb begin
        stateNext     = state;
        faultCodeNext = faultCode;
        retire        = 1'b0;
        memRead       = 1'b0;
        memWriteRaw   = 1'b0;
        iord          = 1'b0;
        irWriteRaw    = 1'b0;
        pcWriteRaw    = 1'b0;
        branchRaw     = 1'b0;
        regWriteRaw   = 1'b0;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = ALUB_RT;
        aluOp         = ALU_ADD;
        pcSrc         = PC_ALU;
        jal           = 1'b0;

        case (state)
            S_IDLE: stateNext = S_FETCH;
            S_FETCH: begin
                memRead = 1'b1;
                if (readyEff) begin
                    irWriteRaw = 1'b1;
                    pcWriteRaw = 1'b1;
                    aluSrcB    = ALUB_FOUR;
                    stateNext  = S_DECODE;
                end else if (timerExpire) begin
                    stateNext     = S_FAULT;
                    faultCodeNext = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                aluSrcB = ALUB_IMMSH;
                case (ctl.opcode)
                    OPCODE_W'(OP_RTYPE): stateNext = (ctl.funct == FUNCT_W'(FN_JR)) ? S_JR : S_EXEC;
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):    stateNext = S_MEMADR;
                    OPCODE_W'(OP_ADDI),
                    OPCODE_W'(OP_ANDI):  stateNext = S_IMMEX;
                    OPCODE_W'(OP_BEQ):   stateNext = S_BRANCH;
                    OPCODE_W'(OP_J):     stateNext = S_JUMP;
                    OPCODE_W'(OP_JAL):   stateNext = S_JAL;
                    default: begin
                        stateNext     = S_FAULT;
                        faultCodeNext = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = ALUB_IMM;
                stateNext = (opLatched == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iord    = 1'b1;
                if (readyEff) begin
                    stateNext = S_MEMWB;
                end else if (timerExpire) begin
                    stateNext     = S_FAULT;
                    faultCodeNext = FC_TIMEOUT;
                end
            end
            S_MEMWB: begin
                regWriteRaw = 1'b1;
                memToReg    = 1'b1;
                retire      = 1'b1;
            end
            S_MEMWR: begin
                memWriteRaw = 1'b1;
                iord        = 1'b1;
                if (readyEff) begin
                    retire = 1'b1;
                end else if (timerExpire) begin
                    stateNext     = S_FAULT;
                    faultCodeNext = FC_TIMEOUT;
                end
            end
            S_EXEC: begin
                aluSrcA   = 1'b1;
                aluOp     = ALU_FUNCT;
                stateNext = S_ALUWB;
            end
            S_ALUWB: begin
                regWriteRaw = 1'b1;
                regDst      = 1'b1;
                retire      = 1'b1;
            end
            S_IMMEX: begin
                aluSrcA   = 1'b1;
                aluSrcB   = ALUB_IMM;
                aluOp     = (opLatched == OPCODE_W'(OP_ANDI)) ? ALU_AND : ALU_ADD;
                stateNext = S_IMMWB;
            end
            S_IMMWB: begin
                regWriteRaw = 1'b1;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA   = 1'b1;
                aluOp     = ALU_SUB;
                branchRaw = 1'b1;
                pcSrc     = PC_ALUOUT;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pcWriteRaw = 1'b1;
                pcSrc      = PC_JUMP;
                retire     = 1'b1;
            end
            S_JAL: begin
                pcWriteRaw  = 1'b1;
                pcSrc       = PC_JUMP;
                regWriteRaw = 1'b1;
                jal         = 1'b1;
                retire      = 1'b1;
            end
            S_JR: begin
                pcWriteRaw = 1'b1;
                pcSrc      = PC_RS;
                retire     = 1'b1;
            end
            S_FAULT: stateNext = S_FAULT;
            default: stateNext = S_IDLE;
        endcase

        if (retire) begin
            stateNext = S_FETCH;
        end

        if (ctl.stall) begin
            stateNext     = state;
            faultCodeNext = faultCode;
            retire        = 1'b0;
        end
    end

    assign ctl.mem_read   = memRead;
    assign ctl.mem_write  = memWriteRaw & ~ctl.stall;
    assign ctl.iord       = iord;
    assign ctl.ir_write   = irWriteRaw & ~ctl.stall;
    assign ctl.pc_write   = pcWriteRaw & ~ctl.stall;
    assign ctl.branch     = branchRaw & ~ctl.stall;
    assign ctl.reg_write  = regWriteRaw & ~ctl.stall;
    assign ctl.reg_dst    = regDst;
    assign ctl.mem_to_reg = memToReg;
    assign ctl.alu_src_a  = aluSrcA;
    assign ctl.alu_src_b  = aluSrcB;
    assign ctl.alu_op     = aluOp;
    assign ctl.pc_src     = pcSrc;
    assign ctl.jal        = jal;
    assign ctl.instr_done = retire;
    assign ctl.fault      = (state == S_FAULT);
    assign ctl.fault_code = faultCode;
    assign ctl.retired    = retiredCnt;

endmodule

// File: tb/tb_multicycle_cpu_control.sv
// Directed bench for multicycle_cpu_control: vector table plus hand-written wait/stall/fault/reset sequences.
module tb_multicycle_cpu_control;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       iord;
        logic       irWrite;
        logic       pcWrite;
        logic       branch;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       jal;
        logic       instrDone;
        logic       fault;
        logic [1:0] faultCode;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       stl;
        exp_t       e;
        logic [1:0] ret;
    } vec_t;

    localparam exp_t E_ZERO       = '0;
    localparam exp_t E_FETCH_RDY  = '{memRead:1'b1, irWrite:1'b1, pcWrite:1'b1, aluSrcB:2'b01, default:0};
    localparam exp_t E_FETCH_WAIT = '{memRead:1'b1, default:0};
    localparam exp_t E_DECODE     = '{aluSrcB:2'b11, default:0};
    localparam exp_t E_EXEC       = '{aluSrcA:1'b1, aluOp:2'b10, default:0};
    localparam exp_t E_ALUWB      = '{regWrite:1'b1, regDst:1'b1, instrDone:1'b1, default:0};
    localparam exp_t E_ALUWB_STL  = '{regDst:1'b1, default:0};
    localparam exp_t E_IMMEX_ADD  = '{aluSrcA:1'b1, aluSrcB:2'b10, default:0};
    localparam exp_t E_IMMEX_AND  = '{aluSrcA:1'b1, aluSrcB:2'b10, aluOp:2'b11, default:0};
    localparam exp_t E_IMMWB      = '{regWrite:1'b1, instrDone:1'b1, default:0};
    localparam exp_t E_BRANCH     = '{aluSrcA:1'b1, aluOp:2'b01, branch:1'b1, pcSrc:2'b01, instrDone:1'b1, default:0};
    localparam exp_t E_JUMP       = '{pcWrite:1'b1, pcSrc:2'b10, instrDone:1'b1, default:0};
    localparam exp_t E_JAL        = '{pcWrite:1'b1, pcSrc:2'b10, regWrite:1'b1, jal:1'b1, instrDone:1'b1, default:0};
    localparam exp_t E_JR         = '{pcWrite:1'b1, pcSrc:2'b11, instrDone:1'b1, default:0};
    localparam exp_t E_MEMADR     = '{aluSrcA:1'b1, aluSrcB:2'b10, default:0};
    localparam exp_t E_MEMWR      = '{memWrite:1'b1, iord:1'b1, instrDone:1'b1, default:0};
    localparam exp_t E_MEMRD      = '{memRead:1'b1, iord:1'b1, default:0};
    localparam exp_t E_MEMWB      = '{regWrite:1'b1, memToReg:1'b1, instrDone:1'b1, default:0};
    localparam exp_t E_FAULT_TO   = '{fault:1'b1, faultCode:2'b10, default:0};
    localparam exp_t E_FAULT_ILL  = '{fault:1'b1, faultCode:2'b01, default:0};

    localparam logic [5:0] R = 6'b000000, LW = 6'b000010, SW = 6'b000011, ADDI = 6'b000100;
    localparam logic [5:0] ANDI = 6'b000101, BEQ = 6'b000110, J = 6'b001000, JAL = 6'b001001;
    localparam logic [5:0] ILL = 6'b001100, F_ADD = 6'b100000, F_JR = 6'b001000;

    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nFails  = 0;
    vec_t vecs[$];

    multicycle_cpu_control_if #(.OPCODE_W(6), .FUNCT_W(6), .RETIRE_W(2)) bus ();

    multicycle_cpu_control #(
        .OPCODE_W(6), .FUNCT_W(6), .MEM_TIMEOUT(4), .RETIRE_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic exp_t sampleOut();
        exp_t g;
        g.memRead   = bus.mem_read;
        g.memWrite  = bus.mem_write;
        g.iord      = bus.iord;
        g.irWrite   = bus.ir_write;
        g.pcWrite   = bus.pc_write;
        g.branch    = bus.branch;
        g.regWrite  = bus.reg_write;
        g.regDst    = bus.reg_dst;
        g.memToReg  = bus.mem_to_reg;
        g.aluSrcA   = bus.alu_src_a;
        g.aluSrcB   = bus.alu_src_b;
        g.aluOp     = bus.alu_op;
        g.pcSrc     = bus.pc_src;
        g.jal       = bus.jal;
        g.instrDone = bus.instr_done;
        g.fault     = bus.fault;
        g.faultCode = bus.fault_code;
        return g;
    endfunction

    task automatic check(input string name, input exp_t e, input logic [1:0] ret);
        exp_t g;
        g = sampleOut();
        nChecks++;
        if (g !== e || bus.retired !== ret) begin
            nFails++;
            $display("FAIL %s: outputs got %h want %h, retired got %0d want %0d",
                     name, g, e, bus.retired, ret);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs checked at the falling edge.
    task automatic cycle(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic rdy, input logic stl, input exp_t e, input logic [1:0] ret);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        bus.stall     = stl;
        #4;
        check(name, e, ret);
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                          input exp_t e, input logic [1:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.stl = 1'b0; v.e = e; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.stall = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        check("reset_state", E_ZERO, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.opcode = '0;
        bus.funct = '0;
        bus.mem_ready = 1'b1;
        bus.stall = 1'b0;
        reset = 1'b1;

        // Back-to-back instruction mix; retired wraps 3->0 on the 4th retire.
        addVec(R,    F_ADD, 1'b1, E_ZERO,      2'd0);
        addVec(R,    F_ADD, 1'b1, E_FETCH_RDY, 2'd0);
        addVec(R,    F_ADD, 1'b1, E_DECODE,    2'd0);
        addVec(R,    F_ADD, 1'b1, E_EXEC,      2'd0);
        addVec(R,    F_ADD, 1'b1, E_ALUWB,     2'd0);
        addVec(ADDI, 6'd0,  1'b1, E_FETCH_RDY, 2'd1);
        addVec(ADDI, 6'd0,  1'b1, E_DECODE,    2'd1);
        addVec(ADDI, 6'd0,  1'b1, E_IMMEX_ADD, 2'd1);
        addVec(ADDI, 6'd0,  1'b1, E_IMMWB,     2'd1);
        addVec(ANDI, 6'd0,  1'b1, E_FETCH_RDY, 2'd2);
        addVec(ANDI, 6'd0,  1'b1, E_DECODE,    2'd2);
        addVec(ADDI, 6'd0,  1'b1, E_IMMEX_AND, 2'd2);
        addVec(ADDI, 6'd0,  1'b1, E_IMMWB,     2'd2);
        addVec(BEQ,  6'd0,  1'b1, E_FETCH_RDY, 2'd3);
        addVec(BEQ,  6'd0,  1'b1, E_DECODE,    2'd3);
        addVec(BEQ,  6'd0,  1'b1, E_BRANCH,    2'd3);
        addVec(J,    6'd0,  1'b1, E_FETCH_RDY, 2'd0);
        addVec(J,    6'd0,  1'b1, E_DECODE,    2'd0);
        addVec(J,    6'd0,  1'b1, E_JUMP,      2'd0);
        addVec(JAL,  6'd0,  1'b1, E_FETCH_RDY, 2'd1);
        addVec(JAL,  6'd0,  1'b1, E_DECODE,    2'd1);
        addVec(JAL,  6'd0,  1'b1, E_JAL,       2'd1);
        addVec(R,    F_JR,  1'b1, E_FETCH_RDY, 2'd2);
        addVec(R,    F_JR,  1'b1, E_DECODE,    2'd2);
        addVec(R,    F_JR,  1'b1, E_JR,        2'd2);
        addVec(SW,   6'd0,  1'b1, E_FETCH_RDY, 2'd3);
        addVec(SW,   6'd0,  1'b1, E_DECODE,    2'd3);
        addVec(LW,   6'd0,  1'b1, E_MEMADR,    2'd3);
        addVec(LW,   6'd0,  1'b1, E_MEMWR,     2'd3);
        addVec(LW,   6'd0,  1'b1, E_FETCH_RDY, 2'd0);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].rdy, vecs[i].stl,
                  vecs[i].e, vecs[i].ret);
        end

        // LW with three wait states in MEMRD, ready on the timeout boundary cycle.
        cycle("lw_decode", LW, 6'd0, 1'b1, 1'b0, E_DECODE, 2'd0);
        cycle("lw_memadr", LW, 6'd0, 1'b1, 1'b0, E_MEMADR, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("lw_wait%0d", i), LW, 6'd0, 1'b0, 1'b0, E_MEMRD, 2'd0);
        end
        cycle("lw_memrd_rdy", LW, 6'd0, 1'b1, 1'b0, E_MEMRD, 2'd0);
        cycle("lw_memwb", LW, 6'd0, 1'b1, 1'b0, E_MEMWB, 2'd0);

        // Stall in FETCH ignores ready; stall in ALUWB suppresses reg_write and retire.
        cycle("fetch_stall", R, F_ADD, 1'b1, 1'b1, E_FETCH_WAIT, 2'd1);
        cycle("fetch_after_stall", R, F_ADD, 1'b1, 1'b0, E_FETCH_RDY, 2'd1);
        cycle("r_decode", R, F_ADD, 1'b1, 1'b0, E_DECODE, 2'd1);
        cycle("r_exec", R, F_ADD, 1'b1, 1'b0, E_EXEC, 2'd1);
        cycle("aluwb_stall0", R, F_ADD, 1'b1, 1'b1, E_ALUWB_STL, 2'd1);
        cycle("aluwb_stall1", R, F_ADD, 1'b1, 1'b1, E_ALUWB_STL, 2'd1);
        cycle("aluwb_release", R, F_ADD, 1'b1, 1'b0, E_ALUWB, 2'd1);

        // FETCH with mem_ready low for MEM_TIMEOUT cycles faults with code 10 and stays there.
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("to_wait%0d", i), R, 6'd0, 1'b0, 1'b0, E_FETCH_WAIT, 2'd2);
        end
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("to_fault%0d", i), R, 6'd0, 1'b1, 1'b0, E_FAULT_TO, 2'd2);
        end

        // Illegal opcode faults with code 01; no enables after FETCH.
        doReset();
        cycle("ill_idle", ILL, 6'd0, 1'b1, 1'b0, E_ZERO, 2'd0);
        cycle("ill_fetch", ILL, 6'd0, 1'b1, 1'b0, E_FETCH_RDY, 2'd0);
        cycle("ill_decode", ILL, 6'd0, 1'b1, 1'b0, E_DECODE, 2'd0);
        cycle("ill_fault0", R, 6'd0, 1'b1, 1'b0, E_FAULT_ILL, 2'd0);
        cycle("ill_fault1", R, 6'd0, 1'b1, 1'b0, E_FAULT_ILL, 2'd0);

        // Asynchronous reset in ALUWB clears reg_write immediately.
        doReset();
        cycle("ar_idle", R, F_ADD, 1'b1, 1'b0, E_ZERO, 2'd0);
        cycle("ar_fetch", R, F_ADD, 1'b1, 1'b0, E_FETCH_RDY, 2'd0);
        cycle("ar_decode", R, F_ADD, 1'b1, 1'b0, E_DECODE, 2'd0);
        cycle("ar_exec", R, F_ADD, 1'b1, 1'b0, E_EXEC, 2'd0);
        #2;
        check("ar_aluwb", E_ALUWB, 2'd0);
        reset = 1'b1;
        #1;
        check("ar_async_clear", E_ZERO, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("ar_restart_idle", R, F_ADD, 1'b1, 1'b0, E_ZERO, 2'd0);
        cycle("ar_restart_fetch", R, F_ADD, 1'b1, 1'b0, E_FETCH_RDY, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
